// File: rtl/memory_sequencer.sv
// memory_sequencer: drives bursts of word transfers between a serializer or
// deserializer and one of two memory blocks.
// Build option: define SEQ_ABORT_EN to add an abort input. While the burst is
// in RUN, abort drops it back to IDLE with no done pulse.
module memory_sequencer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       op_write,
  input  logic       block_sel,
  input  logic [7:0] base_addr,
  input  logic [7:0] word_count,
  input  logic       ser_ready,
  input  logic       deser_valid,
`ifdef SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic [1:0] memoryena,
  output logic [7:0] mem_addr,
  output logic       mem_go,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t     state;
  logic [7:0] remaining;
  logic       handshake;
  logic       abort_req;

`ifdef SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Only the handshake that matches the latched direction can move a word.
  always_comb begin
    handshake = memoryena[0] ? deser_valid : ser_ready;
    mem_go    = (state == RUN) && handshake && !abort_req;
  end

  // Burst control: latch the request, step address/count per transfer, pulse done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      memoryena <= '0;
      mem_addr  <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            memoryena <= {block_sel, op_write};
            mem_addr  <= base_addr;
            remaining <= word_count;
            busy      <= 1'b1;
            if (word_count == 8'd0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (mem_go) begin
            mem_addr  <= mem_addr + 8'd1;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sequencer.sv
// tb_memory_sequencer: directed and randomized bursts against a
// transaction-level expectation (k-th transfer at base+k, done after count).
module tb_memory_sequencer;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       op_write;
  logic       block_sel;
  logic [7:0] base_addr;
  logic [7:0] word_count;
  logic       ser_ready;
  logic       deser_valid;
`ifdef SEQ_ABORT_EN
  logic       abort;
`endif
  logic [1:0] memoryena;
  logic [7:0] mem_addr;
  logic       mem_go;
  logic       busy;
  logic       done;

  int unsigned checks = 0;
  int unsigned passes = 0;

  memory_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .op_write   (op_write),
    .block_sel  (block_sel),
    .base_addr  (base_addr),
    .word_count (word_count),
    .ser_ready  (ser_ready),
    .deser_valid(deser_valid),
`ifdef SEQ_ABORT_EN
    .abort      (abort),
`endif
    .memoryena  (memoryena),
    .mem_addr   (mem_addr),
    .mem_go     (mem_go),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // mode 0: handshake always high, 1: toggles 1/0, 2: random.
  task automatic burst(input logic op, input logic blk, input logic [7:0] base,
                       input logic [7:0] cnt, input int mode);
    int unsigned k;
    int unsigned guard;
    logic        hs;
    logic [1:0]  ena;
    logic [7:0]  a;
    ena = {blk, op};
    start = 1'b1; op_write = op; block_sel = blk; base_addr = base; word_count = cnt;
    ser_ready = 1'($urandom); deser_valid = 1'($urandom);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_go", mem_go, 0);
    tick();
    k = 0;
    guard = 0;
    while (k < cnt && guard < 2000) begin
      case (mode)
        0:       hs = 1'b1;
        1:       hs = (guard % 2 == 0);
        default: hs = 1'($urandom);
      endcase
      // the latched fields must ignore everything driven here
      start = 1'($urandom); op_write = 1'($urandom); block_sel = 1'($urandom);
      base_addr = 8'($urandom); word_count = 8'($urandom);
      if (op) begin
        deser_valid = hs; ser_ready = 1'($urandom);
      end else begin
        ser_ready = hs; deser_valid = 1'($urandom);
      end
      a = base + k[7:0];
      #1;
      chk("run_go", mem_go, hs);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_ena", memoryena, ena);
      chk("run_addr", mem_addr, a);
      if (hs) k++;
      guard++;
      tick();
    end
    chk("burst_words", k, cnt);
    start = 1'b1; ser_ready = 1'b1; deser_valid = 1'b1;
    a = base + cnt;
    #1;
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 1);
    chk("fin_go", mem_go, 0);
    chk("fin_addr", mem_addr, a);
    chk("fin_ena", memoryena, ena);
    tick();
    start = 1'b0;
    #1;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_go", mem_go, 0);
    chk("post_addr", mem_addr, a);
    chk("post_ena", memoryena, ena);
    tick();
  endtask

  initial begin
    resetn = 1'b0; start = 1'b1; op_write = 1'b1; block_sel = 1'b1;
    base_addr = 8'h55; word_count = 8'h07; ser_ready = 1'b1; deser_valid = 1'b1;
`ifdef SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    #1;
    chk("rst_ena", memoryena, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_go", mem_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    resetn = 1'b1; start = 1'b0;
    tick();
    #1;
    chk("idle_hold_busy", busy, 0);
    chk("idle_hold_go", mem_go, 0);
    tick();

    // read blk2, base 0A, three words, ser_ready held high
    burst(1'b0, 1'b1, 8'h0A, 8'd3, 0);
    // write blk1 across the address wrap, deser_valid toggling
    burst(1'b1, 1'b0, 8'hFE, 8'd4, 1);
    // empty burst
    burst(1'b1, 1'b1, 8'h33, 8'd0, 2);
    // longest burst
    burst(1'b0, 1'b0, 8'h80, 8'd255, 0);

    // reset after two of five words abandons the burst
    start = 1'b1; op_write = 1'b0; block_sel = 1'b1; base_addr = 8'h20; word_count = 8'd5;
    tick();
    start = 1'b0; ser_ready = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      #1;
      chk("mid_go", mem_go, 1);
      chk("mid_addr", mem_addr, 32'h20 + i);
      tick();
    end
    resetn = 1'b0;
    tick();
    #1;
    chk("mid_rst_ena", memoryena, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_go", mem_go, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    resetn = 1'b1;
    tick();
    #1;
    chk("mid_rst_nodone", done, 0);
    chk("mid_rst_idle", busy, 0);
    tick();

`ifdef SEQ_ABORT_EN
    // abort after one of four words
    start = 1'b1; op_write = 1'b1; block_sel = 1'b0; base_addr = 8'h40; word_count = 8'd4;
    tick();
    start = 1'b0; deser_valid = 1'b1;
    #1;
    chk("ab_go1", mem_go, 1);
    tick();
    abort = 1'b1;
    #1;
    chk("ab_go_forced", mem_go, 0);
    tick();
    abort = 1'b0;
    #1;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_addr", mem_addr, 8'h41);
    chk("ab_ena", memoryena, 2'b01);
    chk("ab_go_idle", mem_go, 0);
    tick();
    #1;
    chk("ab_nodone", done, 0);
    tick();
`endif

    for (int unsigned n = 0; n < 20; n++) begin
      burst(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom_range(0, 12)), 2);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/memory_sequencer.md
MEMORY_SEQUENCER -- requirements
Module: memory_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and resetn.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  synchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op_write  input  1  0 = read burst, 1 = write burst; latched on accepted start.
REQ-006 block_sel  input  1  0 = block 1, 1 = block 2; latched on accepted start.
REQ-007 base_addr  input  8  first word address; latched on accepted start.
REQ-008 word_count  input  8  number of words, 0..255; latched on accepted start.
REQ-009 ser_ready  input  1  serializer accepts one read word this cycle.
REQ-010 deser_valid  input  1  deserializer presents one word to write this cycle.
REQ-011 memoryena  output  2  operation code {block_sel, op_write}: 00 rd blk1, 01 wr blk1, 10 rd blk2, 11 wr blk2.
REQ-012 mem_addr  output  8  current word address, registered.
REQ-013 mem_go  output  1  a memory word transfer happens this cycle.
REQ-014 busy  output  1  high in RUN and FINISH.
REQ-015 done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and FINISH.
REQ-017 IDLE->RUN when start=1 and word_count!=0; IDLE->FINISH when start=1 and word_count=0; IDLE holds otherwise.
REQ-018 On an accepted start, mem_addr SHALL load base_addr, a remaining counter SHALL load word_count, and memoryena SHALL load {block_sel, op_write}, all on the same edge.
REQ-019 memoryena SHALL remain constant from the accepted start until the next accepted start.
REQ-020 mem_go SHALL be combinational: RUN and (op_write ? deser_valid : ser_ready); it SHALL be 0 outside RUN.
REQ-021 On each mem_go cycle, mem_addr SHALL increment by 1 modulo 256 (FF wraps to 00), and remaining SHALL decrement by 1.
REQ-022 RUN->FINISH on the mem_go cycle where remaining=1; there SHALL be no extra transfer.
REQ-023 FINISH SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-024 start SHALL be ignored in RUN and FINISH; a start in the same cycle as the FINISH->IDLE transition SHALL be ignored.
REQ-025 ser_ready and deser_valid SHALL be ignored when they do not match the latched op_write.
REQ-026 Burst latency SHALL be word_count handshake cycles plus 2 (1 for start, 1 for FINISH); with the handshake input held high, done SHALL assert word_count+1 cycles after start.

Reset
REQ-027 When resetn=0 at a rising edge, the state SHALL become IDLE, memoryena=00, mem_addr=00, remaining=0, done=0, busy=0; mem_go is therefore 0.
REQ-028 A reset during RUN or FINISH SHALL abandon the burst without asserting done.

Configuration
REQ-029 Macro SEQ_ABORT_EN: when defined, an input abort (1 bit) SHALL exist; abort=1 in RUN SHALL force IDLE on the next edge with no done pulse, mem_go forced to 0 that cycle, and mem_addr and memoryena holding their values.
REQ-030 When SEQ_ABORT_EN is undefined, the abort port SHALL NOT exist and RUN SHALL exit only through REQ-022 or reset.

Verification
REQ-031 Read blk2, base 10, count 3, ser_ready=1 constantly -> memoryena=10, mem_go for 3 cycles at addr 10,11,12, done 1 cycle later, mem_addr=13.
REQ-032 Write blk1, base FE, count 4, deser_valid toggling 1/0 -> addresses FE,FF,00,01 on mem_go only, memoryena=01, done after the 4th transfer.
REQ-033 start with word_count=0 -> FINISH the next cycle, done pulse, mem_go never asserted.
REQ-034 A second start during RUN with different op values -> ignored; memoryena and the count unchanged.
REQ-035 resetn=0 mid-burst after 2 of 5 words -> all outputs at reset values the next cycle, no done.
REQ-036 With SEQ_ABORT_EN, abort after 1 of 4 words -> IDLE the next cycle, no done, mem_addr=base+1.
